// File: rtl/cr_prefix_fe_hist_ctr_pkg.sv
// Shared types, defaults and helpers for the prefix-engine front-end histogram counter.
// Pair matching (val1/msk1/pair_en) is only consumed when CR_PREFIX_FE_PAIR_EN is defined.
package cr_prefixPKG;

    localparam int FE_NUM_LANES_DEF  = 8;
    localparam int FE_NUM_CHUNKS_DEF = 4;
    localparam int FE_CTR_W_DEF      = 8;
    localparam int FE_FIFO_DEPTH_DEF = 4;

    // Record fields are sized for the largest legal parameter set and trimmed at the ports.
    localparam int FE_IDX_MAX_W = 4;
    localparam int FE_CNT_MAX_W = 16;

    typedef struct packed {
        logic [7:0] val0;
        logic [7:0] msk0;
        logic [7:0] val1;
        logic [7:0] msk1;
        logic       pair_en;
    } fe_pair_cfg_t;

    typedef struct packed {
        logic [FE_IDX_MAX_W-1:0] idx;
        logic [FE_CNT_MAX_W-1:0] count;
        logic                    sat;
    } fe_hist_res_t;

    function automatic logic [4:0] fe_popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cr_prefix_fe_hist_ctr_lane_cmp.sv
// Per-lane byte comparator: masked equality of one data byte against the chunk pattern.
// The second-byte comparator only exists when CR_PREFIX_FE_PAIR_EN is defined.
module cr_prefix_fe_lane_cmp (
    input  logic [7:0] lane_byte,
    input  logic [7:0] val0,
    input  logic [7:0] msk0,
`ifdef CR_PREFIX_FE_PAIR_EN
    input  logic [7:0] val1,
    input  logic [7:0] msk1,
    output logic       hit1,
`endif
    output logic       hit0
);

    assign hit0 = (((lane_byte ^ val0) & msk0) == 8'h00);

`ifdef CR_PREFIX_FE_PAIR_EN
    assign hit1 = (((lane_byte ^ val1) & msk1) == 8'h00);
`endif

endmodule

// File: rtl/cr_prefix_fe_hist_ctr.sv
// Feature-histogram counter: per-lane pattern match, saturating block count, slot commit, result FIFO.
// Define CR_PREFIX_FE_PAIR_EN to compile in byte-pair matching across lanes and beats.
module cr_prefix_fe_hist_ctr
    import cr_prefixPKG::*;
#(
    parameter int NUM_LANES  = FE_NUM_LANES_DEF,
    parameter int NUM_CHUNKS = FE_NUM_CHUNKS_DEF,
    parameter int CTR_W      = FE_CTR_W_DEF,
    parameter int FIFO_DEPTH = FE_FIFO_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  fe_pair_cfg_t [NUM_CHUNKS-1:0]      fe_config,
    input  logic [NUM_LANES*8-1:0]             fe_char_in,
    input  logic [NUM_LANES-1:0]               fe_char_vbytes,
    input  logic                               fe_ctlr_eodb,
    input  logic [$clog2(NUM_CHUNKS)-1:0]      fe_sel,
    input  logic                               fe_clear,
    output logic [NUM_LANES-1:0]               fe_match_out,
    output logic [NUM_CHUNKS*CTR_W-1:0]        fe_slot,
    output logic [NUM_CHUNKS-1:0]              fe_slot_vld,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [$clog2(NUM_CHUNKS)-1:0]      res_idx,
    output logic [CTR_W-1:0]                   res_count,
    output logic                               res_sat,
    output logic                               fe_ovfl
);

    localparam int SEL_W = $clog2(NUM_CHUNKS);
    localparam int SUM_W = $clog2(NUM_LANES) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [SEL_W-1:0]                   sel_eff;
    fe_pair_cfg_t                       cfg;
    logic [NUM_LANES-1:0]               hit0;
    logic [NUM_LANES-1:0]               match;
    logic [SUM_W-1:0]                   sum;
    logic [31:0]                        acc;
    logic [CTR_W-1:0]                   ctr_q;
    logic [CTR_W-1:0]                   ctr_n;
    logic                               sat_q;
    logic                               sat_n;
    logic [NUM_LANES-1:0]               match_q;
    logic [NUM_CHUNKS-1:0][CTR_W-1:0]   slot_q;
    logic [NUM_CHUNKS-1:0]              slot_vld_q;
    logic                               ovfl_q;

    fe_hist_res_t                       fifo_mem [FIFO_DEPTH];
    fe_hist_res_t                       push_rec;
    fe_hist_res_t                       rd_rec;
    logic [PTR_W-1:0]                   wr_ptr;
    logic [PTR_W-1:0]                   rd_ptr;
    logic [CNT_W-1:0]                   fifo_cnt;
    logic                               push;
    logic                               pop;
    logic                               full;
    logic                               accept;
    logic                               unused_rec;

`ifdef CR_PREFIX_FE_PAIR_EN
    logic [NUM_LANES-1:0]               hit1;
    logic [NUM_LANES-1:0]               prev1;
    logic                               prior1_q;
    logic                               last_hit1;
`else
    logic                               unused_pair_cfg;
`endif

    // Out-of-range selects fold onto the last chunk.
    always_comb begin
        sel_eff = fe_sel;
        if (int'(fe_sel) >= NUM_CHUNKS) begin
            sel_eff = SEL_W'(NUM_CHUNKS - 1);
        end
    end

    assign cfg = fe_config[sel_eff];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        cr_prefix_fe_lane_cmp u_cmp (
            .lane_byte (fe_char_in[8*i +: 8]),
            .val0      (cfg.val0),
            .msk0      (cfg.msk0),
`ifdef CR_PREFIX_FE_PAIR_EN
            .val1      (cfg.val1),
            .msk1      (cfg.msk1),
            .hit1      (hit1[i]),
`endif
            .hit0      (hit0[i])
        );
    end

`ifdef CR_PREFIX_FE_PAIR_EN
    // Lane 0 pairs with the last valid lane of the previous non-empty beat.
    assign prev1 = {hit1[NUM_LANES-2:0], prior1_q};
    assign match = fe_char_vbytes & hit0 & ({NUM_LANES{~cfg.pair_en}} | prev1);

    always_comb begin
        last_hit1 = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (fe_char_vbytes[i]) begin
                last_hit1 = hit1[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prior1_q <= 1'b0;
        end else if (fe_clear || fe_ctlr_eodb) begin
            prior1_q <= 1'b0;
        end else if (|fe_char_vbytes) begin
            prior1_q <= last_hit1;
        end
    end
`else
    assign match = fe_char_vbytes & hit0;
    assign unused_pair_cfg = ^{cfg.val1, cfg.msk1, cfg.pair_en};
`endif

    assign sum = SUM_W'(fe_popcount(16'(match)));

    // Saturation flag is sticky for the block once the clamp engages or the count sits at max.
    always_comb begin
        acc   = 32'(ctr_q) + 32'(sum);
        ctr_n = (acc > 32'(CTR_MAX)) ? CTR_MAX : acc[CTR_W-1:0];
        sat_n = sat_q | (acc > 32'(CTR_MAX)) | (ctr_q == CTR_MAX);
    end

    assign push   = fe_ctlr_eodb & ~fe_clear;
    assign res_valid = (fifo_cnt != '0);
    assign pop    = res_valid & res_ready;
    assign full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign accept = push & (~full | pop);

    always_comb begin
        push_rec       = '0;
        push_rec.idx   = FE_IDX_MAX_W'(sel_eff);
        push_rec.count = FE_CNT_MAX_W'(ctr_n);
        push_rec.sat   = sat_n;
    end

    // Clear wipes the block state and slots but never touches queued results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q    <= '0;
            slot_q     <= '0;
            slot_vld_q <= '0;
            ctr_q      <= '0;
            sat_q      <= 1'b0;
            ovfl_q     <= 1'b0;
        end else begin
            match_q <= match;
            if (fe_clear) begin
                slot_q     <= '0;
                slot_vld_q <= '0;
                ctr_q      <= '0;
                sat_q      <= 1'b0;
                ovfl_q     <= 1'b0;
            end else begin
                if (fe_ctlr_eodb) begin
                    slot_q[sel_eff]     <= ctr_n;
                    slot_vld_q[sel_eff] <= 1'b1;
                    ctr_q               <= '0;
                    sat_q               <= 1'b0;
                end else begin
                    ctr_q <= ctr_n;
                    sat_q <= sat_n;
                end
                if (push && full && !pop) begin
                    ovfl_q <= 1'b1;
                end
            end
        end
    end

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= push_rec;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({accept, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rd_rec     = fifo_mem[rd_ptr];
    assign unused_rec = ^{rd_rec.idx, rd_rec.count};

    assign res_idx   = res_valid ? rd_rec.idx[SEL_W-1:0]   : '0;
    assign res_count = res_valid ? rd_rec.count[CTR_W-1:0] : '0;
    assign res_sat   = res_valid & rd_rec.sat;

    assign fe_match_out = match_q;
    assign fe_slot      = slot_q;
    assign fe_slot_vld  = slot_vld_q;
    assign fe_ovfl      = ovfl_q;

endmodule

// File: tb/tb_cr_prefix_fe_hist_ctr.sv
// Scoreboard bench for cr_prefix_fe_hist_ctr; expected results follow CR_PREFIX_FE_PAIR_EN if defined.
module tb_cr_prefix_fe_hist_ctr;
    import cr_prefixPKG::*;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] cnt;
        logic       sat;
    } exp_rec_t;

    logic                    clk;
    logic                    rst;
    fe_pair_cfg_t [3:0]      fe_config;
    logic [63:0]             fe_char_in;
    logic [7:0]              fe_char_vbytes;
    logic                    fe_ctlr_eodb;
    logic [1:0]              fe_sel;
    logic                    fe_clear;
    logic [7:0]              fe_match_out;
    logic [31:0]             fe_slot;
    logic [3:0]              fe_slot_vld;
    logic                    res_valid;
    logic                    res_ready;
    logic [1:0]              res_idx;
    logic [7:0]              res_count;
    logic                    res_sat;
    logic                    fe_ovfl;

    int checks_total;
    int checks_passed;

    exp_rec_t    exp_q[$];
    logic [3:0][7:0] m_slot;
    logic [3:0]  m_vld;
    logic [7:0]  m_ctr;
    logic        m_sat;
    logic        m_prior1;
    logic        m_ovfl;

    cr_prefix_fe_hist_ctr #(
        .NUM_LANES  (8),
        .NUM_CHUNKS (4),
        .CTR_W      (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fe_config      (fe_config),
        .fe_char_in     (fe_char_in),
        .fe_char_vbytes (fe_char_vbytes),
        .fe_ctlr_eodb   (fe_ctlr_eodb),
        .fe_sel         (fe_sel),
        .fe_clear       (fe_clear),
        .fe_match_out   (fe_match_out),
        .fe_slot        (fe_slot),
        .fe_slot_vld    (fe_slot_vld),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_idx        (res_idx),
        .res_count      (res_count),
        .res_sat        (res_sat),
        .fe_ovfl        (fe_ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic modelReset();
        m_slot   = '0;
        m_vld    = '0;
        m_ctr    = '0;
        m_sat    = 1'b0;
        m_prior1 = 1'b0;
        m_ovfl   = 1'b0;
        exp_q.delete();
    endtask

    // One beat, entered and left one time unit after a rising edge.
    task automatic applyStimulus(input logic [63:0] data, input logic [7:0] vb, input logic eo,
                                 input logic [1:0] s, input logic clr);
        fe_pair_cfg_t c;
        logic [7:0]   mm;
        logic [7:0]   b;
        logic         h0;
        logic         h1;
        logic         prev_h1;
        logic         last_h1;
        int           sum;
        int           acc;
        logic [7:0]   ctr_n;
        logic         sat_n;
        exp_rec_t     rec;
        logic         pop;

        fe_char_in     = data;
        fe_char_vbytes = vb;
        fe_ctlr_eodb   = eo;
        fe_sel         = s;
        fe_clear       = clr;

        c       = fe_config[s];
        prev_h1 = m_prior1;
        last_h1 = 1'b0;
        mm      = '0;
        sum     = 0;
        for (int i = 0; i < 8; i++) begin
            b  = data[8*i +: 8];
            h0 = (((b ^ c.val0) & c.msk0) == 8'h00);
            h1 = (((b ^ c.val1) & c.msk1) == 8'h00);
`ifdef CR_PREFIX_FE_PAIR_EN
            mm[i] = vb[i] & h0 & (~c.pair_en | prev_h1);
`else
            mm[i] = vb[i] & h0;
`endif
            prev_h1 = h1;
            if (vb[i]) last_h1 = h1;
            if (mm[i]) sum++;
        end
        acc   = int'(m_ctr) + sum;
        ctr_n = (acc > 255) ? 8'hFF : acc[7:0];
        sat_n = m_sat | (acc > 255) | (m_ctr == 8'hFF);

        #4;
        pop = 1'b0;
        checkOutput("res_valid", {31'd0, res_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            checkOutput("res_idx",   {30'd0, res_idx},  {30'd0, exp_q[0].idx});
            checkOutput("res_count", {24'd0, res_count}, {24'd0, exp_q[0].cnt});
            checkOutput("res_sat",   {31'd0, res_sat},  {31'd0, exp_q[0].sat});
            pop = res_ready;
            if (pop) rec = exp_q.pop_front();
        end

        if (clr) begin
            m_slot   = '0;
            m_vld    = '0;
            m_ctr    = '0;
            m_sat    = 1'b0;
            m_prior1 = 1'b0;
            m_ovfl   = 1'b0;
        end else if (eo) begin
            m_slot[s] = ctr_n;
            m_vld[s]  = 1'b1;
            m_ctr     = '0;
            m_sat     = 1'b0;
            m_prior1  = 1'b0;
            rec.idx   = s;
            rec.cnt   = ctr_n;
            rec.sat   = sat_n;
            if (exp_q.size() < DEPTH) exp_q.push_back(rec);
            else m_ovfl = 1'b1;
        end else begin
            m_ctr = ctr_n;
            m_sat = sat_n;
            if (vb != 8'h00) m_prior1 = last_h1;
        end

        @(posedge clk);
        #1;
        if (!clr) checkOutput("match_out", {24'd0, fe_match_out}, {24'd0, mm});
        checkOutput("slot",     fe_slot, m_slot);
        checkOutput("slot_vld", {28'd0, fe_slot_vld}, {28'd0, m_vld});
        checkOutput("ovfl",     {31'd0, fe_ovfl}, {31'd0, m_ovfl});
        fe_ctlr_eodb = 1'b0;
        fe_clear     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(64'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        logic [63:0] d;
        int          exp_pair;

        checks_total  = 0;
        checks_passed = 0;
        modelReset();

        fe_config[0] = '{val0: 8'h55, msk0: 8'hFF, val1: 8'h00, msk1: 8'h00, pair_en: 1'b0};
        fe_config[1] = '{val0: 8'h0A, msk0: 8'hFF, val1: 8'h0D, msk1: 8'hFF, pair_en: 1'b1};
        fe_config[2] = '{val0: 8'h41, msk0: 8'hFF, val1: 8'h00, msk1: 8'h00, pair_en: 1'b0};
        fe_config[3] = '{val0: 8'h00, msk0: 8'h00, val1: 8'h00, msk1: 8'h00, pair_en: 1'b0};
        fe_char_in     = '0;
        fe_char_vbytes = '0;
        fe_ctlr_eodb   = 1'b0;
        fe_sel         = '0;
        fe_clear       = 1'b0;
        res_ready      = 1'b1;
        rst            = 1'b1;

        #3;
        checkOutput("rst_match", {24'd0, fe_match_out}, 32'd0);
        checkOutput("rst_slot",  fe_slot, 32'd0);
        checkOutput("rst_vld",   {28'd0, fe_slot_vld}, 32'd0);
        checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_count", {24'd0, res_count}, 32'd0);
        checkOutput("rst_ovfl",  {31'd0, fe_ovfl}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single-byte count");
        applyStimulus({8{8'h41}}, 8'hFF, 1'b0, 2'd2, 1'b0);
        applyStimulus({8{8'h41}}, 8'hFF, 1'b0, 2'd2, 1'b0);
        applyStimulus({8{8'h41}}, 8'hFF, 1'b1, 2'd2, 1'b0);
        checkOutput("slot2_24",  {24'd0, fe_slot[23:16]}, 32'd24);
        checkOutput("res_cnt24", {24'd0, res_count}, 32'd24);
        checkOutput("res_idx2",  {30'd0, res_idx}, 32'd2);
        applyStimulus({4{8'h41, 8'h20}}, 8'h0F, 1'b1, 2'd2, 1'b0);
        checkOutput("slot2_2", {24'd0, fe_slot[23:16]}, 32'd2);

        $display("[TB] pair across beats");
        d = '0;
        d[63:56] = 8'h0D;
        applyStimulus(d, 8'hFF, 1'b0, 2'd1, 1'b0);
        applyStimulus(64'd0, 8'h00, 1'b0, 2'd1, 1'b0);
        d = '0;
        d[7:0]   = 8'h0A;
        d[31:24] = 8'h0D;
        d[39:32] = 8'h0A;
        d[55:48] = 8'h0A;
        applyStimulus(d, 8'hFF, 1'b1, 2'd1, 1'b0);
`ifdef CR_PREFIX_FE_PAIR_EN
        exp_pair = 2;
`else
        exp_pair = 3;
`endif
        checkOutput("pair_slot1", {24'd0, fe_slot[15:8]}, exp_pair);

        $display("[TB] saturation");
        for (int k = 0; k < 31; k++) applyStimulus({8{8'h33}}, 8'hFF, 1'b0, 2'd3, 1'b0);
        applyStimulus({8{8'h33}}, 8'hFF, 1'b1, 2'd3, 1'b0);
        checkOutput("sat_slot3", {24'd0, fe_slot[31:24]}, 32'd255);
        applyStimulus({8{8'h33}}, 8'h07, 1'b1, 2'd3, 1'b0);
        checkOutput("sat_next0", {24'd0, fe_slot[31:24]}, 32'd3);
        checkOutput("sat_next_res", {31'd0, res_sat}, 32'd0);
        idle(1);

        $display("[TB] fifo full");
        res_ready = 1'b0;
        applyStimulus({8{8'h12}}, 8'h03, 1'b1, 2'd3, 1'b0);
        applyStimulus({8{8'h12}}, 8'h0F, 1'b1, 2'd3, 1'b0);
        applyStimulus({8{8'h55}}, 8'hFF, 1'b1, 2'd0, 1'b0);
        checkOutput("full_ovfl",  {31'd0, fe_ovfl}, 32'd1);
        checkOutput("full_slot0", {24'd0, fe_slot[7:0]}, 32'd8);
        checkOutput("full_head",  {24'd0, res_count}, 32'd2);
        idle(1);
        res_ready = 1'b1;
        idle(3);
        checkOutput("drained", {31'd0, res_valid}, 32'd0);

        $display("[TB] clear with eodb");
        applyStimulus({8{8'h00}}, 8'hFF, 1'b0, 2'd3, 1'b0);
        applyStimulus({8{8'h00}}, 8'hFF, 1'b1, 2'd3, 1'b1);
        checkOutput("clr_slot",  fe_slot, 32'd0);
        checkOutput("clr_vld",   {28'd0, fe_slot_vld}, 32'd0);
        checkOutput("clr_nopush", {31'd0, res_valid}, 32'd0);
        applyStimulus(64'd0, 8'h00, 1'b1, 2'd3, 1'b0);
        checkOutput("clr_cnt0", {24'd0, res_count}, 32'd0);
        checkOutput("clr_vld3", {28'd0, fe_slot_vld}, 32'h8);
        idle(1);

        $display("[TB] async reset mid-block");
        res_ready = 1'b0;
        applyStimulus({8{8'h41}}, 8'hFF, 1'b1, 2'd2, 1'b0);
        applyStimulus({8{8'h41}}, 8'hFF, 1'b0, 2'd3, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("arst_count", {24'd0, res_count}, 32'd0);
        checkOutput("arst_slot",  fe_slot, 32'd0);
        checkOutput("arst_vld",   {28'd0, fe_slot_vld}, 32'd0);
        checkOutput("arst_match", {24'd0, fe_match_out}, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        applyStimulus({8{8'h41}}, 8'h0F, 1'b1, 2'd3, 1'b0);
        checkOutput("arst_fresh", {24'd0, res_count}, 32'd4);
        idle(2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
